count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/counter_pkg.sv | 13 +
 rtl/sat_counter.sv | 33 +++
 rtl/count_monitor.sv | 157 +++++++++++++++
 tb/tb_count_monitor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the count monitor: FSM state encoding and direction constants.
package counter_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a synchronous clear takes priority over an increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/count_monitor.sv
// Watches an external up/down counter, locks after LOCK_N correct steps and reports
// step errors, direction changes and wraps while locked.
module count_monitor
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LOCK_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic [WIDTH-1:0] count,
    input  logic             clr_stats,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic             dir_change,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_up_cnt,
    output logic [CNT_W-1:0] wrap_dn_cnt
);

    localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_N);

    state_t            state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic [WIDTH-1:0]  prev_count_q, prev_count_d, expected;
    logic              prev_ud_q, prev_ud_d;
    logic              match;
    logic              err_ev, dir_ev, wrap_up_ev, wrap_dn_ev;
    logic              locked_q, err_pulse_q, dir_change_q;
    logic              err_sticky_q, err_sticky_d;

    assign expected = (prev_ud_q == DIR_DN) ? prev_count_q - WIDTH'(1)
                                            : prev_count_q + WIDTH'(1);
    // A held count never equals the expected value, so it falls out as a mismatch.
    assign match    = (count == expected);
    assign good_inc = good_q + GOOD_W'(1);

    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        prev_count_d = prev_count_q;
        prev_ud_d    = prev_ud_q;
        err_ev       = 1'b0;
        dir_ev       = 1'b0;
        wrap_up_ev   = 1'b0;
        wrap_dn_ev   = 1'b0;
        if (!en) begin
            state_d = SYNC;
            good_d  = '0;
        end else begin
            prev_count_d = count;
            prev_ud_d    = up_down;
            case (state_q)
                SYNC: begin
                    state_d = ACQ;
                    good_d  = '0;
                end
                ACQ: begin
                    if (!match) begin
                        good_d = '0;
                    end else if (good_inc == GOOD_TGT) begin
                        state_d = TRACK;
                        good_d  = '0;
                    end else begin
                        good_d = good_inc;
                    end
                end
                TRACK: begin
                    dir_ev     = (up_down != prev_ud_q);
                    wrap_up_ev = (prev_ud_q == DIR_UP) && (prev_count_q == '1) && (count == '0);
                    wrap_dn_ev = (prev_ud_q == DIR_DN) && (prev_count_q == '0) && (count == '1);
                    if (!match) begin
                        err_ev  = 1'b1;
                        state_d = ACQ;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = SYNC;
                    good_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        err_sticky_d = err_sticky_q;
        if (clr_stats) begin
            err_sticky_d = 1'b0;
        end else if (err_ev) begin
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SYNC;
            good_q       <= '0;
            prev_count_q <= '0;
            prev_ud_q    <= 1'b0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            dir_change_q <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            prev_count_q <= prev_count_d;
            prev_ud_q    <= prev_ud_d;
            locked_q     <= (state_d == TRACK);
            err_pulse_q  <= err_ev;
            dir_change_q <= dir_ev;
            err_sticky_q <= err_sticky_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_ev),
        .clr (clr_stats),
        .cnt (err_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_wrap_up_cnt (
        .clk (clk),
        .rst (rst),
        .inc (wrap_up_ev),
        .clr (clr_stats),
        .cnt (wrap_up_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_wrap_dn_cnt (
        .clk (clk),
        .rst (rst),
        .inc (wrap_dn_ev),
        .clr (clr_stats),
        .cnt (wrap_dn_cnt)
    );

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign dir_change = dir_change_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_count_monitor.sv
// Scoreboard bench for count_monitor: stimulus queues expected outputs, a monitor checks them.
module tb_count_monitor;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LOCK_N = 2;

    typedef struct packed {
        logic             locked;
        logic             err_pulse;
        logic             err_sticky;
        logic             dir_change;
        logic [CNT_W-1:0] err_cnt;
        logic [CNT_W-1:0] wrap_up;
        logic [CNT_W-1:0] wrap_dn;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             up_down;
    logic [WIDTH-1:0] count;
    logic             clr_stats;
    logic             locked, err_pulse, err_sticky, dir_change;
    logic [CNT_W-1:0] err_cnt, wrap_up_cnt, wrap_dn_cnt;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    logic [CNT_W-1:0] m_err, m_wu, m_wd;
    logic             m_sticky;

    count_monitor #(
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W),
        .LOCK_N (LOCK_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .up_down     (up_down),
        .count       (count),
        .clr_stats   (clr_stats),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_sticky  (err_sticky),
        .dir_change  (dir_change),
        .err_cnt     (err_cnt),
        .wrap_up_cnt (wrap_up_cnt),
        .wrap_dn_cnt (wrap_dn_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
    endfunction

    task automatic model_zero();
        m_err = '0; m_wu = '0; m_wd = '0; m_sticky = 1'b0;
    endtask

    task automatic push_exp(input logic xl, input logic xe, input logic xd, input string nm);
        obs_t e;
        e = {xl, xe, m_sticky, xd, m_err, m_wu, m_wd};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One sample edge: drive inputs, update the statistics model from the hand-given events.
    task automatic step(input logic e, input logic ud, input logic [WIDTH-1:0] c,
                        input logic clr, input logic xl, input logic xe, input logic xd,
                        input logic xwu, input logic xwd, input string nm);
        @(negedge clk);
        en = e; up_down = ud; count = c; clr_stats = clr;
        if (clr) begin
            model_zero();
        end else begin
            if (xe) begin
                m_err = sat_inc(m_err);
                m_sticky = 1'b1;
            end
            if (xwu) m_wu = sat_inc(m_wu);
            if (xwd) m_wd = sat_inc(m_wd);
        end
        push_exp(xl, xe, xd, nm);
    endtask

    // Monitor: compare on every clock edge and on asynchronous reset entry.
    initial begin
        obs_t  e, a;
        string nm;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {locked, err_pulse, err_sticky, dir_change, err_cnt, wrap_up_cnt, wrap_dn_cnt};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s: got lk=%0b ep=%0b es=%0b dc=%0b ec=%0d wu=%0d wd=%0d, expected lk=%0b ep=%0b es=%0b dc=%0b ec=%0d wu=%0d wd=%0d",
                             nm, a.locked, a.err_pulse, a.err_sticky, a.dir_change, a.err_cnt,
                             a.wrap_up, a.wrap_dn, e.locked, e.err_pulse, e.err_sticky,
                             e.dir_change, e.err_cnt, e.wrap_up, e.wrap_dn);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] c;
        rst = 1'b0; en = 1'b0; up_down = 1'b0; count = '0; clr_stats = 1'b0;
        model_zero();
        step(1'b1, 1'b1, 4'd5, 1'b0, 0, 0, 0, 0, 0, "reset_state");
        @(negedge clk);
        rst = 1'b1;

        // Lock acquisition from reset.
        step(1'b1, 1'b1, 4'd0, 1'b0, 0, 0, 0, 0, 0, "acq_sync");
        step(1'b1, 1'b1, 4'd1, 1'b0, 0, 0, 0, 0, 0, "acq_good1");
        step(1'b1, 1'b1, 4'd2, 1'b0, 1, 0, 0, 0, 0, "acq_lock");
        step(1'b1, 1'b1, 4'd3, 1'b0, 1, 0, 0, 0, 0, "track_3");
        for (int i = 4; i <= 15; i++) begin
            step(1'b1, 1'b1, 4'(i), 1'b0, 1, 0, 0, 0, 0, "track_up");
        end

        // Up wrap, direction change, down wrap.
        step(1'b1, 1'b1, 4'd0,  1'b0, 1, 0, 0, 1, 0, "wrap_up");
        step(1'b1, 1'b0, 4'd1,  1'b0, 1, 0, 1, 0, 0, "dir_change");
        step(1'b1, 1'b0, 4'd0,  1'b0, 1, 0, 0, 0, 0, "down_0");
        step(1'b1, 1'b0, 4'd15, 1'b0, 1, 0, 0, 0, 1, "wrap_dn");
        step(1'b1, 1'b0, 4'd14, 1'b0, 1, 0, 0, 0, 0, "down_14");
        for (int i = 13; i >= 6; i--) begin
            step(1'b1, 1'b0, 4'(i), 1'b0, 1, 0, 0, 0, 0, "track_dn");
        end

        // Error injection and relock.
        step(1'b1, 1'b1, 4'd5, 1'b0, 1, 0, 1, 0, 0, "turn_up_5");
        step(1'b1, 1'b1, 4'd9, 1'b0, 0, 1, 0, 0, 0, "inject_9");
        step(1'b1, 1'b1, 4'd6, 1'b0, 0, 0, 0, 0, 0, "reacq_6");
        step(1'b1, 1'b1, 4'd7, 1'b0, 0, 0, 0, 0, 0, "reacq_7");
        step(1'b1, 1'b1, 4'd8, 1'b0, 1, 0, 0, 0, 0, "relock_8");

        // Error counter saturation.
        c = 4'd8;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, c + 4'd3, 1'b0, 0, 1, 0, 0, 0, $sformatf("sat_err_%0d", i));
            step(1'b1, 1'b1, c + 4'd4, 1'b0, 0, 0, 0, 0, 0, "sat_reacq");
            step(1'b1, 1'b1, c + 4'd5, 1'b0, 1, 0, 0, 0, 0, "sat_relock");
            c = c + 4'd5;
        end

        // Clear coinciding with an error: clear wins, pulse still fires.
        step(1'b1, 1'b1, c + 4'd3, 1'b1, 0, 1, 0, 0, 0, "clr_vs_err");
        step(1'b1, 1'b1, c + 4'd4, 1'b0, 0, 0, 0, 0, 0, "clr_reacq");
        step(1'b1, 1'b1, c + 4'd5, 1'b0, 1, 0, 0, 0, 0, "clr_relock");
        c = c + 4'd5;
        while (c != 4'd7) begin
            c = c + 4'd1;
            step(1'b1, 1'b1, c, 1'b0, 1, 0, 0, (c == 4'd0), 0, "walk_to_7");
        end

        // Asynchronous reset while locked.
        @(negedge clk);
        #2;
        model_zero();
        push_exp(0, 0, 0, "async_reset");
        rst = 1'b0;
        step(1'b0, 1'b1, 4'd8, 1'b0, 0, 0, 0, 0, 0, "in_reset");
        @(negedge clk);
        rst = 1'b1;

        // Held count while locked.
        step(1'b1, 1'b1, 4'd2, 1'b0, 0, 0, 0, 0, 0, "post_rst_sync");
        step(1'b1, 1'b1, 4'd3, 1'b0, 0, 0, 0, 0, 0, "post_rst_good");
        step(1'b1, 1'b1, 4'd4, 1'b0, 1, 0, 0, 0, 0, "post_rst_lock");
        step(1'b1, 1'b1, 4'd4, 1'b0, 0, 1, 0, 0, 0, "held_count");
        step(1'b1, 1'b1, 4'd5, 1'b0, 0, 0, 0, 0, 0, "held_reacq");
        step(1'b1, 1'b1, 4'd6, 1'b0, 1, 0, 0, 0, 0, "held_relock");
        step(1'b1, 1'b1, 4'd7, 1'b0, 1, 0, 0, 0, 0, "held_track");

        // Enable dropped for three cycles, then relock.
        step(1'b0, 1'b0, 4'd8, 1'b0, 0, 0, 0, 0, 0, "en_off_1");
        step(1'b0, 1'b1, 4'd3, 1'b0, 0, 0, 0, 0, 0, "en_off_2");
        step(1'b0, 1'b0, 4'd9, 1'b0, 0, 0, 0, 0, 0, "en_off_3");
        step(1'b1, 1'b1, 4'd10, 1'b0, 0, 0, 0, 0, 0, "en_on_sync");
        step(1'b1, 1'b1, 4'd11, 1'b0, 0, 0, 0, 0, 0, "en_on_good");
        step(1'b1, 1'b1, 4'd12, 1'b0, 1, 0, 0, 0, 0, "en_on_lock");
        step(1'b1, 1'b1, 4'd13, 1'b0, 1, 0, 0, 0, 0, "en_on_track");

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
